sound_multi_tick_timer: RTL

//  Multi-channel programmable tick generator for the sound/VGA timing path.

---
 rtl/sound_multi_tick_timer_if.sv | 28 ++
 rtl/sound_multi_tick_timer.sv | 102 ++++++++++
 2 files changed

// File: rtl/sound_multi_tick_timer_if.sv
// Control and tick bus between the game control FSM (master) and the
// multi-channel tick timer (slave).
interface sound_multi_tick_timer_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 26
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic                turbo;
   logic                cfg_wr;
   logic [CH_W-1:0]     cfg_ch;
   logic [CNT_W-1:0]    cfg_period;
   logic                cfg_mode;
   logic [NUM_CH-1:0]   start;
   logic [NUM_CH-1:0]   stop;
   logic [NUM_CH-1:0]   tick;
   logic [NUM_CH-1:0]   busy;

   modport master (
      output turbo, cfg_wr, cfg_ch, cfg_period, cfg_mode, start, stop,
      input  tick, busy
   );

   modport slave (
      input  turbo, cfg_wr, cfg_ch, cfg_period, cfg_mode, start, stop,
      output tick, busy
   );
endinterface

// File: rtl/sound_multi_tick_timer.sv
// Multi-channel programmable tick generator: each channel divides clk by its
// own period (optionally shortened by turbo) and emits periodic or one-shot ticks.
module sound_multi_tick_timer #(
   parameter int NUM_CH         = 4,
   parameter int CNT_W          = 26,
   parameter int DEFAULT_PERIOD = 31_500_000,
   parameter int TURBO_DIV      = 10
) (
   input  logic                     clk,
   input  logic                     resetN,
   sound_multi_tick_timer_if.slave  bus
);
   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [CNT_W-1:0] DEF_P   = CNT_W'(DEFAULT_PERIOD);
   localparam logic [CNT_W-1:0] DIV_W   = CNT_W'(TURBO_DIV);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   state_t              state_q    [NUM_CH];
   state_t              state_d    [NUM_CH];
   logic [CNT_W-1:0]    cnt_q      [NUM_CH];
   logic [CNT_W-1:0]    cnt_d      [NUM_CH];
   logic [CNT_W-1:0]    period_q   [NUM_CH];
   logic [CNT_W-1:0]    period_d   [NUM_CH];
   logic [CNT_W-1:0]    eff_w      [NUM_CH];
   logic [CNT_W-1:0]    last_cnt   [NUM_CH];
   logic [NUM_CH-1:0]   mode_q;
   logic [NUM_CH-1:0]   mode_d;
   logic [NUM_CH-1:0]   tick_q;
   logic [NUM_CH-1:0]   tick_d;
   logic [NUM_CH-1:0]   busy_w;

   // Effective period is recomputed every cycle, so cfg and turbo changes take
   // effect immediately on a running channel; a zero result behaves as 1.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         eff_w[i]    = bus.turbo ? (period_q[i] / DIV_W) : period_q[i];
         last_cnt[i] = (eff_w[i] == '0) ? '0 : (eff_w[i] - ONE);
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      mode_d   = mode_q;
      tick_d   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (bus.stop[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
         end else if (bus.start[i]) begin
            state_d[i] = RUN;
            cnt_d[i]   = '0;
         end else if (state_q[i] == RUN) begin
            // >= rather than == so a period shrunk below the count wraps at once
            if (cnt_q[i] >= last_cnt[i]) begin
               tick_d[i] = 1'b1;
               cnt_d[i]  = '0;
               if (mode_q[i]) begin
                  state_d[i] = IDLE;
               end
            end else begin
               cnt_d[i] = cnt_q[i] + ONE;
            end
         end else begin
            cnt_d[i] = '0;
         end
      end
      if (bus.cfg_wr && (32'(bus.cfg_ch) < NUM_CH)) begin
         period_d[bus.cfg_ch] = bus.cfg_period;
         mode_d[bus.cfg_ch]   = bus.cfg_mode;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i]  <= IDLE;
            cnt_q[i]    <= '0;
            period_q[i] <= DEF_P;
         end
         mode_q <= '0;
         tick_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         mode_q   <= mode_d;
         tick_q   <= tick_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         busy_w[i] = (state_q[i] == RUN);
      end
   end

   assign bus.tick = tick_q;
   assign bus.busy = busy_w;
endmodule
